// File: rtl/line_sensor_filter_if.sv
// Line sensor filter bus: ADC samples in, filtered averages,
// line flags, steering code and node events out.
interface line_sensor_filter_if;
  logic        en;
  logic [11:0] ADC_DATA_CH1;
  logic [11:0] ADC_DATA_CH2;
  logic [11:0] ADC_DATA_CH3;
  logic [11:0] avg_ch1;
  logic [11:0] avg_ch2;
  logic [11:0] avg_ch3;
  logic [2:0]  on_line;
  logic [1:0]  dir;
  logic        node_pulse;
  logic [3:0]  node_count;
  logic        data_valid;

  modport master (
    output en, ADC_DATA_CH1, ADC_DATA_CH2, ADC_DATA_CH3,
    input  avg_ch1, avg_ch2, avg_ch3, on_line, dir,
    input  node_pulse, node_count, data_valid
  );

  modport slave (
    input  en, ADC_DATA_CH1, ADC_DATA_CH2, ADC_DATA_CH3,
    output avg_ch1, avg_ch2, avg_ch3, on_line, dir,
    output node_pulse, node_count, data_valid
  );
endinterface

// File: rtl/line_sensor_filter.sv
// Box-car averages three ADC channels, applies hysteresis,
// and derives steering direction plus junction (node) events.
module line_sensor_filter #(
  parameter int SAMPLE_PERIOD = 48,
  parameter int AVG_LOG2      = 2,
  parameter int TH_HI         = 1800,
  parameter int TH_LO         = 1500
) (
  input  logic                 sclk,
  input  logic                 rst,
  line_sensor_filter_if.slave  bus
);
  localparam int PW = (SAMPLE_PERIOD > 2) ?
                      $clog2(SAMPLE_PERIOD) : 2;
  localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW = 12 + AVG_LOG2;
  localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [SW-1:0] S_LAST = SW'((1 << AVG_LOG2) - 1);
  localparam logic [11:0]   HI     = 12'(TH_HI);
  localparam logic [11:0]   LO     = 12'(TH_LO);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_UPDATE, S_DECIDE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_period;
  logic [SW-1:0] r_smp;
  logic [AW-1:0] r_acc1;
  logic [AW-1:0] r_acc2;
  logic [AW-1:0] r_acc3;
  logic [11:0]   r_avg1;
  logic [11:0]   r_avg2;
  logic [11:0]   r_avg3;
  logic [2:0]    r_on;
  logic [2:0]    w_on;
  logic [1:0]    r_dir;
  logic          r_np;
  logic          r_dv;
  logic [3:0]    r_cnt;
  logic          w_strobe;
  logic          w_last;
  logic          w_node;

  function automatic logic hyst(
    input logic [11:0] a,
    input logic        cur
  );
    logic r;
    r = cur;
    if (a >= HI)
      r = 1'b1;
    else if (a < LO)
      r = 1'b0;
    return r;
  endfunction

  function automatic logic [1:0] dir_of(
    input logic [2:0] on
  );
    logic [1:0] d;
    case (on)
      3'b010, 3'b111: d = 2'b00;
      3'b100, 3'b110: d = 2'b01;
      3'b001, 3'b011: d = 2'b10;
      default:        d = 2'b11;
    endcase
    return d;
  endfunction

  assign w_strobe = bus.en && (r_state == S_RUN) &&
                    (r_period == P_LAST);
  assign w_last   = w_strobe && (r_smp == S_LAST);

  assign w_on = {hyst(r_avg1, r_on[2]),
                 hyst(r_avg2, r_on[1]),
                 hyst(r_avg3, r_on[0])};
  assign w_node = (w_on == 3'b111) && (r_on != 3'b111);

  // FSM state register
  always_ff @(posedge sclk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; dropping en always returns to idle
  always_comb begin
    w_next = r_state;
    if (!bus.en) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   w_next = S_RUN;
        S_RUN:    if (w_last) w_next = S_UPDATE;
        S_UPDATE: w_next = S_DECIDE;
        S_DECIDE: w_next = S_RUN;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Sample cadence counter; free-runs while enabled
  always_ff @(posedge sclk or posedge rst) begin
    if (rst)
      r_period <= '0;
    else if (!bus.en || r_period == P_LAST)
      r_period <= '0;
    else
      r_period <= r_period + 1'b1;
  end

  // Accumulate on each strobe; clear on idle or after averaging
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_acc1 <= '0;
      r_acc2 <= '0;
      r_acc3 <= '0;
      r_smp  <= '0;
    end else if (!bus.en || r_state == S_IDLE ||
                 r_state == S_UPDATE) begin
      r_acc1 <= '0;
      r_acc2 <= '0;
      r_acc3 <= '0;
      r_smp  <= '0;
    end else if (w_strobe) begin
      r_acc1 <= r_acc1 + AW'(bus.ADC_DATA_CH1);
      r_acc2 <= r_acc2 + AW'(bus.ADC_DATA_CH2);
      r_acc3 <= r_acc3 + AW'(bus.ADC_DATA_CH3);
      r_smp  <= r_smp + 1'b1;
    end
  end

  // Latch truncated averages
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_avg1 <= '0;
      r_avg2 <= '0;
      r_avg3 <= '0;
    end else if (bus.en && r_state == S_UPDATE) begin
      r_avg1 <= 12'(r_acc1 >> AVG_LOG2);
      r_avg2 <= 12'(r_acc2 >> AVG_LOG2);
      r_avg3 <= 12'(r_acc3 >> AVG_LOG2);
    end
  end

  // Classify, steer and count nodes; pulses only in decide
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_on  <= '0;
      r_dir <= 2'b11;
      r_np  <= 1'b0;
      r_dv  <= 1'b0;
      r_cnt <= '0;
    end else if (bus.en && r_state == S_DECIDE) begin
      r_on  <= w_on;
      r_dir <= dir_of(w_on);
      r_np  <= w_node;
      r_dv  <= 1'b1;
      if (w_node)
        r_cnt <= r_cnt + 4'd1;
    end else begin
      r_np <= 1'b0;
      r_dv <= 1'b0;
    end
  end

  assign bus.avg_ch1    = r_avg1;
  assign bus.avg_ch2    = r_avg2;
  assign bus.avg_ch3    = r_avg3;
  assign bus.on_line    = r_on;
  assign bus.dir        = r_dir;
  assign bus.node_pulse = r_np;
  assign bus.node_count = r_cnt;
  assign bus.data_valid = r_dv;
endmodule

// File: tb/tb_line_sensor_filter.sv
// Bench for line_sensor_filter: sample-list reference model
// compared every cycle, plus hand-computed directed checks.
module tb_line_sensor_filter;
  localparam int SP = 48;

  logic sclk = 1'b0;
  logic rst  = 1'b1;

  line_sensor_filter_if b();

  line_sensor_filter #(
    .SAMPLE_PERIOD(SP),
    .AVG_LOG2(2),
    .TH_HI(1800),
    .TH_LO(1500)
  ) dut (
    .sclk(sclk),
    .rst(rst),
    .bus(b)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_n  = 0;
  int m_k  = 0;
  int m_s1 = 0;
  int m_s2 = 0;
  int m_s3 = 0;
  int m_p1 = 0;
  int m_p2 = 0;
  int m_p3 = 0;
  int m_du = -1;
  int m_dd = -1;
  logic [11:0] e_a1  = '0;
  logic [11:0] e_a2  = '0;
  logic [11:0] e_a3  = '0;
  logic [2:0]  e_on  = '0;
  logic [1:0]  e_dir = 2'b11;
  logic        e_np  = 1'b0;
  logic        e_dv  = 1'b0;
  logic [3:0]  e_cnt = '0;

  logic [1:0] dir_tab [8] = '{2'b11, 2'b10, 2'b00, 2'b10,
                              2'b01, 2'b11, 2'b01, 2'b00};

  function automatic logic hy(int a, logic cur);
    if (a >= 1800) return 1'b1;
    if (a < 1500) return 1'b0;
    return cur;
  endfunction

  task automatic m_clear();
    m_n  = 0;
    m_k  = 0;
    m_s1 = 0;
    m_s2 = 0;
    m_s3 = 0;
    m_du = -1;
    m_dd = -1;
    e_np = 1'b0;
    e_dv = 1'b0;
  endtask

  task automatic m_step();
    logic [2:0] nw;
    if (rst) begin
      m_clear();
      m_p1  = 0;
      m_p2  = 0;
      m_p3  = 0;
      e_a1  = '0;
      e_a2  = '0;
      e_a3  = '0;
      e_on  = '0;
      e_dir = 2'b11;
      e_cnt = '0;
    end else if (!b.en) begin
      m_clear();
    end else begin
      m_n++;
      e_dv = 1'b0;
      e_np = 1'b0;
      if (m_n == m_du) begin
        e_a1 = 12'(m_p1);
        e_a2 = 12'(m_p2);
        e_a3 = 12'(m_p3);
      end
      if (m_n == m_dd) begin
        nw = {hy(m_p1, e_on[2]), hy(m_p2, e_on[1]),
              hy(m_p3, e_on[0])};
        e_np = (nw == 3'b111) && (e_on != 3'b111);
        if (e_np) e_cnt = e_cnt + 4'd1;
        e_on  = nw;
        e_dir = dir_tab[nw];
        e_dv  = 1'b1;
      end
      if (m_n % SP == 0) begin
        m_s1 += int'(b.ADC_DATA_CH1);
        m_s2 += int'(b.ADC_DATA_CH2);
        m_s3 += int'(b.ADC_DATA_CH3);
        m_k++;
        if (m_k == 4) begin
          m_p1 = m_s1 / 4;
          m_p2 = m_s2 / 4;
          m_p3 = m_s3 / 4;
          m_s1 = 0;
          m_s2 = 0;
          m_s3 = 0;
          m_k  = 0;
          m_du = m_n + 1;
          m_dd = m_n + 2;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge sclk or posedge rst);
    m_step();
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_now();
    logic [46:0] got;
    logic [46:0] exp;
    got = {b.avg_ch1, b.avg_ch2, b.avg_ch3, b.on_line, b.dir,
           b.node_pulse, b.node_count, b.data_valid};
    exp = {e_a1, e_a2, e_a3, e_on, e_dir, e_np, e_cnt, e_dv};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL model t=%0t got avg=%0d,%0d,%0d on=%b dir=%b np=%b cnt=%0d dv=%b want avg=%0d,%0d,%0d on=%b dir=%b np=%b cnt=%0d dv=%b",
               $time, b.avg_ch1, b.avg_ch2, b.avg_ch3, b.on_line,
               b.dir, b.node_pulse, b.node_count, b.data_valid,
               e_a1, e_a2, e_a3, e_on, e_dir, e_np, e_cnt, e_dv);
    end
  endtask

  task automatic tick();
    @(negedge sclk);
    cmp_now();
  endtask

  task automatic set_ch(input int a, input int c, input int d);
    b.ADC_DATA_CH1 = 12'(a);
    b.ADC_DATA_CH2 = 12'(c);
    b.ADC_DATA_CH3 = 12'(d);
  endtask

  task automatic wait_strobe();
    int g;
    g = 0;
    do begin
      tick();
      g++;
    end while (m_n % SP != 0 && g < 2 * SP);
    if (m_n % SP != 0) chk("strobe_wait", m_n % SP, 0);
  endtask

  task automatic do_avg(input int a[4], input int c[4],
                        input int d[4], output int at);
    at = -1;
    for (int j = 0; j < 4; j++) begin
      set_ch(a[j], c[j], d[j]);
      wait_strobe();
    end
    for (int g = 0; g < 4; g++) begin
      tick();
      if (b.data_valid) begin
        at = m_n;
        break;
      end
    end
    if (at < 0) chk("dv_wait", at, 0);
  endtask

  task automatic avg_const(input int a, input int c,
                           input int d, output int at);
    do_avg('{a, a, a, a}, '{c, c, c, c}, '{d, d, d, d}, at);
  endtask

  initial begin
    int at;
    int g;
    int v1, v2, v3;
    b.en = 1'b0;
    set_ch(0, 0, 0);
    repeat (3) tick();
    chk("rst_dir", b.dir, 3);
    chk("rst_on", b.on_line, 0);
    chk("rst_cnt", b.node_count, 0);
    chk("rst_avg2", b.avg_ch2, 0);
    chk("rst_dv", b.data_valid, 0);
    rst = 1'b0;
    repeat (2) tick();

    b.en = 1'b1;
    avg_const(500, 2000, 500, at);
    chk("lat_first", at, 194);
    chk("t1_avg1", b.avg_ch1, 500);
    chk("t1_avg2", b.avg_ch2, 2000);
    chk("t1_avg3", b.avg_ch3, 500);
    chk("t1_on", b.on_line, 3'b010);
    chk("t1_dir", b.dir, 0);

    do_avg('{500, 500, 500, 500}, '{1000, 1001, 1002, 1005},
           '{500, 500, 500, 500}, at);
    chk("t2_avg2", b.avg_ch2, 1002);
    chk("t2_on", b.on_line, 0);
    chk("t2_dir", b.dir, 3);

    avg_const(500, 1900, 500, at);
    chk("hy_1900", b.on_line, 3'b010);
    avg_const(500, 1600, 500, at);
    chk("hy_1600_avg", b.avg_ch2, 1600);
    chk("hy_1600", b.on_line, 3'b010);
    avg_const(500, 1400, 500, at);
    chk("hy_1400", b.on_line, 0);

    avg_const(2000, 2000, 2000, at);
    chk("node1_np", b.node_pulse, 1);
    chk("node1_cnt", b.node_count, 1);
    avg_const(2000, 2000, 2000, at);
    chk("node2_np", b.node_pulse, 0);
    chk("node2_cnt", b.node_count, 1);
    avg_const(500, 2000, 500, at);
    chk("node3_np", b.node_pulse, 0);
    chk("node3_on", b.on_line, 3'b010);
    avg_const(2000, 2000, 2000, at);
    chk("node4_np", b.node_pulse, 1);
    chk("node4_cnt", b.node_count, 2);
    for (int i = 0; i < 14; i++) begin
      avg_const(500, 2000, 500, at);
      avg_const(2000, 2000, 2000, at);
    end
    chk("cnt_wrap", b.node_count, 0);

    for (int c = 0; c < 8; c++) begin
      v1 = c[2] ? 2000 : 500;
      v2 = c[1] ? 2000 : 500;
      v3 = c[0] ? 2000 : 500;
      avg_const(v1, v2, v3, at);
      chk($sformatf("sweep_on_%0d", c), b.on_line, c);
      chk($sformatf("sweep_dir_%0d", c), b.dir, dir_tab[c]);
    end

    set_ch(3000, 3000, 3000);
    wait_strobe();
    wait_strobe();
    b.en = 1'b0;
    repeat (6) tick();
    chk("drop_on", b.on_line, 3'b111);
    chk("drop_cnt", b.node_count, 1);
    chk("drop_dv", b.data_valid, 0);
    b.en = 1'b1;
    avg_const(1000, 1000, 1000, at);
    chk("lat_restart", at, 194);
    chk("restart_avg1", b.avg_ch1, 1000);
    chk("restart_avg3", b.avg_ch3, 1000);

    set_ch(2500, 2500, 2500);
    g = 0;
    while (m_n != 384 && g < 400) begin
      tick();
      g++;
    end
    chk("reach_update", m_n, 384);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_avg1", b.avg_ch1, 0);
    chk("mid_rst_cnt", b.node_count, 0);
    chk("mid_rst_dir", b.dir, 3);
    chk("mid_rst_on", b.on_line, 0);
    chk("mid_rst_dv", b.data_valid, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
